// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types, constants and the round-robin search helper used by the
// sdram_port_arb channel arbiter and its picker sub-module.
//   arb_state_t : arbiter FSM states
//   CNT_W       : width of the access-length down-counter
//   MAX_CH      : largest supported channel count (index width IDX_W)
//   rr_pick()   : first requesting index after 'rr', wrapping at num_ch
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int CNT_W  = 4;
  localparam int MAX_CH = 8;
  localparam int IDX_W  = 3;

  // Searches rr+1, rr+2, ... (mod num_ch) and returns the first index whose
  // request bit is set. Returns rr unchanged when nothing is requesting; the
  // caller qualifies the result with its own "any request" flag.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                              input logic [IDX_W-1:0]  rr,
                                              input int                num_ch);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = rr;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      j = int'(rr) + i;
      // rr < num_ch and i <= num_ch, so one subtraction performs the wrap.
      if (j >= num_ch) j = j - num_ch;
      if ((i <= num_ch) && !found && req[j[IDX_W-1:0]]) begin
        pick  = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// -----------------------------------------------------------------------------
// sdram_arb_rr
// Combinational round-robin picker.
//   req_i       : request vector, one bit per channel
//   ptr_i       : index of the most recently granted channel
//   gnt_idx_o   : first requesting channel after ptr_i (wrap-around)
//   gnt_valid_o : at least one channel is requesting
// -----------------------------------------------------------------------------
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [MAX_CH-1:0] req_ext;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves a value unassigned, which would otherwise infer a latch.
    req_ext     = MAX_CH'(req_i);
    gnt_idx_o   = rr_pick(req_ext, ptr_i, NUM_CH);
    gnt_valid_o = |req_i;
  end

endmodule

// File: rtl/sdram_port_arb.sv
// -----------------------------------------------------------------------------
// sdram_port_arb
// N-channel arbiter multiplexing CPU, video-fetch and loader requests onto the
// single cs/oe/we port of the ssdram controller. Fixed-length accesses of
// ACC_CYC cycles, one-cycle per-channel ack, shared read-data output.
//
// Ports:
//   clock_i, reset_n_i       : clock, asynchronous active-low reset
//   ch_req_i / ch_we_i       : per-channel level request and write flag
//   ch_addr_i / ch_data_i    : packed per-channel address / write data
//   ch_ack_o / ch_data_o     : per-channel completion pulse, shared read data
//   ram_addr_o, ram_data_o, ram_data_i, ram_cs_o, ram_oe_o, ram_we_o : ssdram
//   busy_o                   : a channel holds the grant
//
// Build option: define SDRAM_ARB_CH0_PRIO_EN to give channel 0 absolute
// priority; round-robin then rotates only among channels 1..NUM_CH-1.
// -----------------------------------------------------------------------------
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 8,
  parameter int ACC_CYC = 6
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [NUM_CH-1:0]        ch_ack_o,
  output logic [DATA_W-1:0]        ch_data_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic [DATA_W-1:0]        ram_data_o,
  input  logic [DATA_W-1:0]        ram_data_i,
  output logic                     ram_cs_o,
  output logic                     ram_oe_o,
  output logic                     ram_we_o,
  output logic                     busy_o
);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  gnt_q;
  logic [IDX_W-1:0]  rr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] ack_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_cs_q;
  logic              ram_oe_q;
  logic              ram_we_q;

  // Requests seen by the round-robin picker.
  logic [NUM_CH-1:0] pick_req;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;

`ifdef SDRAM_ARB_CH0_PRIO_EN
  // Channel 0 is handled ahead of the picker, so it never takes part in or
  // moves the rotation.
  assign pick_req = ch_req_i & ~NUM_CH'(1);
`else
  assign pick_req = ch_req_i;
`endif

  sdram_arb_rr #(.NUM_CH(NUM_CH)) u_rr (
    .req_i      (pick_req),
    .ptr_i      (rr_q),
    .gnt_idx_o  (pick_idx),
    .gnt_valid_o(pick_valid)
  );

  // Selected channel's request fields and the one-hot ack vector for gnt_q.
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic              we_sel;
  logic [NUM_CH-1:0] ack_sel;

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    we_sel   = 1'b0;
    ack_sel  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_q == IDX_W'(k)) begin
        addr_sel   = ch_addr_i[k*ADDR_W +: ADDR_W];
        data_sel   = ch_data_i[k*DATA_W +: DATA_W];
        we_sel     = ch_we_i[k];
        ack_sel[k] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written only with <= so every register in this
  // block samples the values from before the clock edge.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= IDX_W'(NUM_CH-1);  // channel 0 wins the first arbitration
      cnt_q      <= '0;
      ack_q      <= '0;
      rd_data_q  <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_cs_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
`ifdef SDRAM_ARB_CH0_PRIO_EN
          if (ch_req_i[0]) begin
            gnt_q   <= '0;
            state_q <= GRANT;
          end else
`endif
          if (pick_valid) begin
            gnt_q   <= pick_idx;
            rr_q    <= pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          ram_addr_q <= addr_sel;
          ram_data_q <= data_sel;
          ram_we_q   <= we_sel;
          ram_oe_q   <= ~we_sel;
          ram_cs_q   <= 1'b1;
          cnt_q      <= CNT_W'(ACC_CYC - 1);
          state_q    <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // Writes leave the shared read-data register untouched.
            if (!ram_we_q) rd_data_q <= ram_data_i;
            ram_cs_q <= 1'b0;
            ram_oe_q <= 1'b0;
            ram_we_q <= 1'b0;
            ack_q    <= ack_sel;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_ack_o   = ack_q;
  assign ch_data_o  = rd_data_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_cs_o   = ram_cs_q;
  assign ram_oe_o   = ram_oe_q;
  assign ram_we_o   = ram_we_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_port_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arb
// Directed bench for sdram_port_arb (NUM_CH=3, ACC_CYC=6). Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising
// edge. With req raised in cycle t, cs is expected from t+2 and ack at t+8.
// -----------------------------------------------------------------------------
module tb_sdram_port_arb;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 8;
  localparam int ACC_CYC = 6;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_ack;
  logic [DATA_W-1:0]        ch_rdata;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_wdata;
  logic [DATA_W-1:0]        ram_rdata;
  logic                     ram_cs, ram_oe, ram_we, busy;

  int total = 0;
  int bad   = 0;

  sdram_port_arb #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(ACC_CYC)
  ) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .ch_req_i  (ch_req),
    .ch_we_i   (ch_we),
    .ch_addr_i (ch_addr),
    .ch_data_i (ch_wdata),
    .ch_ack_o  (ch_ack),
    .ch_data_o (ch_rdata),
    .ram_addr_o(ram_addr),
    .ram_data_o(ram_wdata),
    .ram_data_i(ram_rdata),
    .ram_cs_o  (ram_cs),
    .ram_oe_o  (ram_oe),
    .ram_we_o  (ram_we),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
    ch_we[ch]                   = we;
    ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_wdata[ch*DATA_W +: DATA_W] = data;
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single isolated access on one channel; checks timing, bus values and ack.
  task automatic run_single(input string tag, input int ch, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] exp_dout);
    int cs_cnt = 0, cs_first = -1, ack_at = -1, extra = 0, bus_bad = 0;
    logic [NUM_CH-1:0] ack_val = '0;
    logic [DATA_W-1:0] dout = '0;
    logic busy_start = 1'b0, busy_end = 1'b1;
    ram_rdata = rdata;
    set_ch(ch, we, addr, wdata);
    ch_req[ch] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ram_cs) begin
        cs_cnt++;
        if (cs_first < 0) cs_first = k;
        if (ram_oe !== ~we || ram_we !== we || ram_addr !== addr ||
            (we && ram_wdata !== wdata)) bus_bad++;
      end
      if (|ch_ack) begin
        if (ack_at < 0) begin
          ack_at  = k;
          ack_val = ch_ack;
          dout    = ch_rdata;
        end else extra++;
        ch_req[ch] = 1'b0;
      end
      if (k == 1)  busy_start = busy;
      if (k == 12) busy_end   = busy;
    end
    check({tag, "_cs_len"},   cs_cnt,   ACC_CYC);
    check({tag, "_cs_first"}, cs_first, 2);
    check({tag, "_ack_at"},   ack_at,   ACC_CYC + 2);
    check({tag, "_ack_vec"},  32'(ack_val), 32'(1) << ch);
    check({tag, "_ack_once"}, extra,    0);
    check({tag, "_bus"},      bus_bad,  0);
    check({tag, "_dout"},     dout,     exp_dout);
    check({tag, "_busy_on"},  busy_start, 1);
    check({tag, "_busy_off"}, busy_end,   0);
  endtask

  int order [$];
  int times [$];
  int ack_at [NUM_CH];
  int multi, spacing_bad, cs_rises, cs_win, cs2_first, ack_in_rst;
  logic prev_cs;
  logic [31:0] exp_seq [5];

  initial begin
    rst_n     = 1'b0;
    ch_req    = '0;
    ch_we     = '0;
    ch_addr   = '0;
    ch_wdata  = '0;
    ram_rdata = '0;

    // ---- reset state ---------------------------------------------------------
    repeat (2) @(negedge clk);
    check("rst_ctrl",  {ram_cs, ram_oe, ram_we}, 0);
    check("rst_ack",   ch_ack,   0);
    check("rst_busy",  busy,     0);
    check("rst_dout",  ch_rdata, 0);
    check("rst_addr",  ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single read and single write ---------------------------------------
    run_single("rd_ch1", 1, 1'b0, 25'h00ABCD, 8'h00, 8'h5A, 8'h5A);
    run_single("wr_ch0", 0, 1'b1, 25'h000010, 8'h3C, 8'hFF, 8'h5A);

    // ---- fairness: all channels hold req continuously ------------------------
    pulse_reset(2);
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, ADDR_W'(32'h100 + c), 8'h00);
    ram_rdata = 8'h11;
    ch_req    = '1;
    multi     = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (|ch_ack) begin
        if ($countones(ch_ack) != 1) multi++;
        for (int c = 0; c < NUM_CH; c++) if (ch_ack[c]) order.push_back(c);
        times.push_back(k);
        if (order.size() == 9) begin
          ch_req = '0;
          break;
        end
      end
    end
    check("fair_count", order.size(), 9);
    check("fair_multi", multi, 0);
    if (times.size() > 0) check("fair_first_ack", times[0], ACC_CYC + 2);
    spacing_bad = 0;
    for (int i = 1; i < times.size(); i++)
      if (times[i] - times[i-1] != ACC_CYC + 3) spacing_bad++;
    check("fair_spacing", spacing_bad, 0);
    for (int i = 0; i < order.size(); i++) check($sformatf("fair_gnt%0d", i), order[i], i % 3);
    repeat (2) @(negedge clk);

    // ---- late request: ch2 raises req during ch0's access --------------------
    set_ch(0, 1'b0, 25'h000200, 8'h00);
    set_ch(2, 1'b0, 25'h000202, 8'h00);
    ch_req[0] = 1'b1;
    foreach (ack_at[c]) ack_at[c] = -1;
    cs_rises = 0; cs_win = 0; cs2_first = -1; prev_cs = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= ACC_CYC + 2) begin
        if (ram_cs) cs_win++;
        if (ram_cs && !prev_cs) cs_rises++;
      end else if (ram_cs && cs2_first < 0) cs2_first = k;
      prev_cs = ram_cs;
      for (int c = 0; c < NUM_CH; c++)
        if (ch_ack[c] && ack_at[c] < 0) begin
          ack_at[c] = k;
          ch_req[c] = 1'b0;
        end
      if (k == 4) ch_req[2] = 1'b1;
    end
    check("late_cs_len",   cs_win,    ACC_CYC);
    check("late_cs_rises", cs_rises,  1);
    check("late_ack0",     ack_at[0], ACC_CYC + 2);
    check("late_cs2",      cs2_first, 2 * ACC_CYC - 1);
    check("late_ack2",     ack_at[2], 2 * ACC_CYC + 5);
    check("late_no_ack1",  ack_at[1], -1);

    // ---- async reset in ACCESS cycle 3 ---------------------------------------
    ch_req[0]  = 1'b1;
    ack_in_rst = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (|ch_ack) ack_in_rst++;
    end
    check("arst_cs_before", ram_cs, 1);
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", {ram_cs, ram_oe, ram_we}, 0);
    check("arst_busy", busy, 0);
    ch_req[1] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (|ch_ack) ack_in_rst++;
    end
    check("arst_no_ack", ack_in_rst, 0);
    rst_n = 1'b1;
    foreach (ack_at[c]) ack_at[c] = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++)
        if (ch_ack[c] && ack_at[c] < 0) begin
          ack_at[c] = k;
          ch_req    = '0;
        end
    end
    check("arst_next_ch0", ack_at[0], ACC_CYC + 2);
    check("arst_no_ch1",   ack_at[1], -1);

    // ---- ch0 and ch1 requesting together (rr last = ch0) ---------------------
`ifdef SDRAM_ARB_CH0_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 1};
`else
    exp_seq = '{1, 0, 1, 0, 1};
`endif
    order.delete();
    ch_req = 3'b011;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) if (ch_ack[c]) order.push_back(c);
      if (order.size() == 4 && ch_req[0]) ch_req[0] = 1'b0;
      if (order.size() == 5) begin
        ch_req = '0;
        break;
      end
    end
    check("pair_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++)
      check($sformatf("pair_gnt%0d", i), order[i], exp_seq[i]);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
